// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipeline_hazard_ctrl                                       |
// | Description : Stall/bubble control for a 5-stage in-order pipeline.     |
// |               Handles memory wait, taken branch flush, load-use and      |
// |               multiply/divide unit (MDU) hazards, and instruction-fetch  |
// |               wait. Contains a small IDLE/BUSY FSM that tracks the MDU.  |
// |               Optional performance counters are enabled by defining the  |
// |               macro PIPE_HAZARD_CTRL_PERF_EN.                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_reads_hilo,
    input  logic        id_is_mdu,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mdu_start,
    input  logic        ex_mdu_is_div,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        bubble_ifid,
    output logic        stall_idex,
    output logic        bubble_idex,
    output logic        stall_exmem,
    output logic        bubble_exmem,
    output logic        stall_memwb,
    output logic        bubble_memwb,
    output logic        mdu_busy,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_BUSY     = 1'b1;
    localparam logic [7:0] c_MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] c_DIV_LOAD = 8'(DIV_CYCLES - 1);

    logic [0:0] r_state;
    logic [7:0] r_cnt;
    logic       w_mem_wait;
    logic       w_load_use;
    logic       w_mdu_haz;
    logic       w_mdu_busy;

    // MDU appears idle while reset is held, even mid-operation.
    assign w_mdu_busy = resetn & (r_state == c_BUSY);
    assign mdu_busy   = w_mdu_busy;
    assign w_mem_wait = mem_req & ~mem_ready;
    assign w_load_use = ex_is_load & (ex_rd != 5'd0) &
                        ((id_uses_rs & (id_rs == ex_rd)) |
                         (id_uses_rt & (id_rt == ex_rd)));
    assign w_mdu_haz  = (id_reads_hilo | id_is_mdu) & (w_mdu_busy | ex_mdu_start);

    // MDU tracker: accept a new op only when idle and the pipe is advancing;
    // once busy, count down regardless of memory stalls.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_cnt   <= 8'd0;
        end else if (r_state == c_IDLE) begin
            if (ex_mdu_start && !w_mem_wait) begin
                r_state <= c_BUSY;
                r_cnt   <= ex_mdu_is_div ? c_DIV_LOAD : c_MUL_LOAD;
            end
        end else begin
            if (r_cnt == 8'd0) begin
                r_state <= c_IDLE;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Prioritised stall/bubble decode: reset, memory wait, branch flush,
    // data hazards, then fetch wait.
    always_comb begin
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        bubble_ifid  = 1'b0;
        stall_idex   = 1'b0;
        bubble_idex  = 1'b0;
        stall_exmem  = 1'b0;
        bubble_exmem = 1'b0;
        stall_memwb  = 1'b0;
        bubble_memwb = 1'b0;
        if (!resetn) begin
            bubble_ifid  = 1'b1;
            bubble_idex  = 1'b1;
            bubble_exmem = 1'b1;
            bubble_memwb = 1'b1;
        end else if (w_mem_wait) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            stall_exmem  = 1'b1;
            bubble_memwb = 1'b1;
        end else if (branch_taken) begin
            bubble_ifid  = 1'b1;
            bubble_idex  = 1'b1;
        end else if (w_load_use || w_mdu_haz) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            bubble_idex  = 1'b1;
        end else if (!imem_ready) begin
            stall_pc     = 1'b1;
            bubble_ifid  = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic        w_flush_act;

    // A branch flush only counts when it is not frozen by a memory wait.
    assign w_flush_act = resetn & ~w_mem_wait & branch_taken;

    // Free-running event counters; natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            if (stall_pc) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_flush_act) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_count  = r_perf_flush;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipeline_hazard_ctrl                                    |
// | Description : Directed self-checking bench for pipeline_hazard_ctrl.     |
// |               Honours PIPE_HAZARD_CTRL_PERF_EN for counter expectations. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, id_reads_hilo, id_is_mdu;
    logic        ex_is_load, ex_mdu_start, ex_mdu_is_div;
    logic        branch_taken, imem_ready, mem_req, mem_ready;
    logic        stall_pc, stall_ifid, bubble_ifid, stall_idex, bubble_idex;
    logic        stall_exmem, bubble_exmem, stall_memwb, bubble_memwb;
    logic        mdu_busy;
    logic [31:0] perf_stall_cycles, perf_flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Control vector order:
    // {stall_pc, stall_ifid, bubble_ifid, stall_idex, bubble_idex,
    //  stall_exmem, bubble_exmem, stall_memwb, bubble_memwb}
    localparam logic [8:0] c_V_RESET  = 9'b001010101;
    localparam logic [8:0] c_V_NONE   = 9'b000000000;
    localparam logic [8:0] c_V_HAZ    = 9'b110010000;
    localparam logic [8:0] c_V_IMEM   = 9'b101000000;
    localparam logic [8:0] c_V_BRANCH = 9'b001010000;
    localparam logic [8:0] c_V_MEMW   = 9'b110101001;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) u_dut (
        .clk               (clk),
        .resetn            (resetn),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_uses_rs        (id_uses_rs),
        .id_uses_rt        (id_uses_rt),
        .id_reads_hilo     (id_reads_hilo),
        .id_is_mdu         (id_is_mdu),
        .ex_is_load        (ex_is_load),
        .ex_rd             (ex_rd),
        .ex_mdu_start      (ex_mdu_start),
        .ex_mdu_is_div     (ex_mdu_is_div),
        .branch_taken      (branch_taken),
        .imem_ready        (imem_ready),
        .mem_req           (mem_req),
        .mem_ready         (mem_ready),
        .stall_pc          (stall_pc),
        .stall_ifid        (stall_ifid),
        .bubble_ifid       (bubble_ifid),
        .stall_idex        (stall_idex),
        .bubble_idex       (bubble_idex),
        .stall_exmem       (stall_exmem),
        .bubble_exmem      (bubble_exmem),
        .stall_memwb       (stall_memwb),
        .bubble_memwb      (bubble_memwb),
        .mdu_busy          (mdu_busy),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );

    wire [8:0] w_ctl = {stall_pc, stall_ifid, bubble_ifid, stall_idex, bubble_idex,
                        stall_exmem, bubble_exmem, stall_memwb, bubble_memwb};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reads_hilo = 1'b0; id_is_mdu = 1'b0;
        ex_is_load = 1'b0; ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0;
        branch_taken = 1'b0; imem_ready = 1'b1; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Advance one clock; inputs may change 1 ns after the edge, checks at +2 ns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_busy, n_stall;
        idle_inputs();
        resetn = 1'b0;
        // Reset with noisy inputs: outputs must follow the reset pattern.
        branch_taken = 1'b1; mem_req = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        id_uses_rs = 1'b1; id_rs = 5'd3; ex_mdu_start = 1'b1;
        tick(); tick();
        #1;
        check("reset_ctl", 32'(w_ctl), 32'(c_V_RESET));
        check("reset_busy", 32'(mdu_busy), 32'd0);
        check("reset_perf_stall", perf_stall_cycles, 32'd0);
        check("reset_perf_flush", perf_flush_count, 32'd0);
        idle_inputs();
        #1;
        resetn = 1'b1;
        #1;
        check("idle_ctl", 32'(w_ctl), 32'(c_V_NONE));

        // Load-use on rt, then the same with ex_rd=0, rs path, unused rs.
        ex_is_load = 1'b1; ex_rd = 5'd5; id_uses_rt = 1'b1; id_rt = 5'd5;
        #1; check("load_use_rt", 32'(w_ctl), 32'(c_V_HAZ));
        ex_rd = 5'd0; id_rt = 5'd0;
        #1; check("load_use_r0", 32'(w_ctl), 32'(c_V_NONE));
        idle_inputs();
        ex_is_load = 1'b1; ex_rd = 5'd17; id_uses_rs = 1'b1; id_rs = 5'd17;
        #1; check("load_use_rs", 32'(w_ctl), 32'(c_V_HAZ));
        id_uses_rs = 1'b0;
        #1; check("load_use_unused", 32'(w_ctl), 32'(c_V_NONE));
        id_uses_rs = 1'b1; ex_is_load = 1'b0;
        #1; check("no_load", 32'(w_ctl), 32'(c_V_NONE));

        // Fetch wait alone, under load-use, under branch.
        idle_inputs(); imem_ready = 1'b0;
        #1; check("imem_wait", 32'(w_ctl), 32'(c_V_IMEM));
        ex_is_load = 1'b1; ex_rd = 5'd5; id_uses_rt = 1'b1; id_rt = 5'd5;
        #1; check("load_use_over_imem", 32'(w_ctl), 32'(c_V_HAZ));
        branch_taken = 1'b1;
        #1; check("branch_over_all", 32'(w_ctl), 32'(c_V_BRANCH));
        mem_req = 1'b1; mem_ready = 1'b0;
        #1; check("memwait_over_branch", 32'(w_ctl), 32'(c_V_MEMW));
        mem_ready = 1'b1;
        #1; check("mem_ready_done", 32'(w_ctl), 32'(c_V_BRANCH));
        idle_inputs(); id_is_mdu = 1'b1; ex_mdu_start = 1'b1;
        #1; check("mdu_haz_ex", 32'(w_ctl), 32'(c_V_HAZ));

        // MDU op offered during a memory wait must not be accepted.
        idle_inputs(); ex_mdu_start = 1'b1; mem_req = 1'b1;
        tick();
        idle_inputs();
        #1; check("mdu_blocked_by_memwait", 32'(mdu_busy), 32'd0);

        // Divide with MFHI waiting behind it.
        ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1; id_reads_hilo = 1'b1;
        n_busy = 0; n_stall = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (i == 0) check("div_busy_not_yet", 32'(mdu_busy), 32'd0);
            if (i == 1) check("div_busy_next", 32'(mdu_busy), 32'd1);
            n_busy  += int'(mdu_busy);
            n_stall += int'(stall_pc);
            tick();
            ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0;
        end
        check("div_busy_cycles", 32'(n_busy), 32'd32);
        check("div_stall_cycles", 32'(n_stall), 32'd33);
        idle_inputs();

        // Multiply with a second start while busy: must stay 4 cycles.
        ex_mdu_start = 1'b1;
        n_busy = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ex_mdu_start = (i == 1);
            ex_mdu_is_div = (i == 1);
            #1;
            n_busy += int'(mdu_busy);
        end
        check("mul_restart_ignored", 32'(n_busy), 32'd4);
        idle_inputs();

        // Multiply aborted by reset at its second busy cycle.
        ex_mdu_start = 1'b1;
        tick();
        ex_mdu_start = 1'b0;
        tick();
        #1; check("mul_busy_c2", 32'(mdu_busy), 32'd1);
        resetn = 1'b0;
        #1; check("abort_busy_in_reset", 32'(mdu_busy), 32'd0);
        check("abort_ctl", 32'(w_ctl), 32'(c_V_RESET));
        tick();
        resetn = 1'b1;
        #1; check("abort_busy_after", 32'(mdu_busy), 32'd0);
        check("abort_perf_stall", perf_stall_cycles, 32'd0);
        check("abort_perf_flush", perf_flush_count, 32'd0);

        // Counters: 10 fetch-wait cycles, 2 branches, 3 frozen branches.
        imem_ready = 1'b0;
        repeat (10) tick();
        imem_ready = 1'b1;
        #1; check("perf_stall_10", perf_stall_cycles, c_PERF ? 32'd10 : 32'd0);
        branch_taken = 1'b1;
        repeat (2) tick();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; check("memwait_branch_ctl", 32'(w_ctl), 32'(c_V_MEMW));
            tick();
        end
        idle_inputs();
        #1;
        check("perf_flush_frozen", perf_flush_count, c_PERF ? 32'd2 : 32'd0);
        check("perf_stall_13", perf_stall_cycles, c_PERF ? 32'd13 : 32'd0);
        check("stall_memwb_zero", 32'(stall_memwb), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound on simulation length.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, MDU busy cycles for multiply (legal 2..255).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, MDU busy cycles for divide (legal 2..255).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- resetn  in  1  synchronous, active-low reset
- id_rs, id_rt  in  5 each  ID source registers
- id_uses_rs, id_uses_rt  in  1 each  ID reads rs/rt
- id_reads_hilo  in  1  ID instruction is MFHI/MFLO
- id_is_mdu  in  1  ID instruction is MULT/DIV
- ex_is_load  in  1  EX holds a load
- ex_rd  in  5  EX destination register
- ex_mdu_start  in  1  EX holds MULT/DIV
- ex_mdu_is_div  in  1  EX MDU op is divide
- branch_taken  in  1  EX resolved taken branch/jump
- imem_ready  in  1  instruction fetch data valid
- mem_req, mem_ready  in  1 each  MEM access pending / completes
- stall_pc  out  1  hold PC
- stall_ifid, bubble_ifid, stall_idex, bubble_idex, stall_exmem, bubble_exmem, stall_memwb, bubble_memwb  out  1 each  pipeline register controls (bubble overrides stall in the register)
- mdu_busy  out  1  MDU running
- perf_stall_cycles, perf_flush_count  out  32 each  performance counters

Function
REQ-004 mem_wait = mem_req & !mem_ready; SHALL assert stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_memwb; all other bubbles 0; highest priority after reset.
REQ-005 load_use = ex_is_load & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-006 mdu_haz = (id_reads_hilo | id_is_mdu) & (mdu_busy | ex_mdu_start).
REQ-007 Without mem_wait, branch_taken SHALL assert bubble_ifid and bubble_idex, stall_pc=0; overrides load_use, mdu_haz, imem wait.
REQ-008 Without mem_wait/branch_taken, load_use|mdu_haz SHALL assert stall_pc, stall_ifid, bubble_idex; bubble_ifid=0 even if imem_ready=0.
REQ-009 Without the above, imem_ready=0 SHALL assert stall_pc and bubble_ifid only.
REQ-010 No condition active: all stall/bubble outputs 0.
REQ-011 stall_memwb SHALL always be 0; stall/bubble outputs SHALL be combinational in inputs and state.
REQ-012 MDU FSM states IDLE, BUSY; IDLE->BUSY at edge with ex_mdu_start & !mem_wait; counter loads DIV_CYCLES-1 if ex_mdu_is_div else MUL_CYCLES-1.
REQ-013 In BUSY counter SHALL decrement every cycle (including mem_wait); BUSY->IDLE at edge where counter==0; mdu_busy=1 exactly in BUSY, i.e. N cycles starting the cycle after acceptance.
REQ-014 ex_mdu_start while BUSY SHALL be ignored (no reload).

Reset
REQ-015 While resetn=0 at a clk edge: FSM->IDLE, counter->0, perf counters->0.
REQ-016 While resetn=0: all bubble outputs 1, all stall outputs 0, mdu_busy 0, independent of other inputs; reset mid-BUSY aborts the operation.

Configuration
REQ-017 Macro PIPE_HAZARD_CTRL_PERF_EN defined: perf_stall_cycles increments each cycle stall_pc=1; perf_flush_count increments each cycle branch_taken is acted on (REQ-007); both wrap at 2^32.
REQ-018 Macro undefined: perf ports SHALL exist, driven constant 0, no counter flops.

Verification
REQ-019 Scenario: ex_is_load=1, ex_rd=5, id_uses_rt=1, id_rt=5 -> stall_pc=1, stall_ifid=1, bubble_idex=1; same with ex_rd=0 -> all 0.
REQ-020 Scenario: ex_mdu_start=1, ex_mdu_is_div=1 one cycle, then id_reads_hilo=1 held -> mdu_busy high exactly 32 cycles, stall_pc high 33 cycles.
REQ-021 Scenario: branch_taken=1 with load_use=1 and imem_ready=0 -> bubble_ifid=1, bubble_idex=1, stall_pc=0.
REQ-022 Scenario: mem_req=1, mem_ready=0 for 3 cycles with branch_taken=1 -> stall_pc/ifid/idex/exmem=1, bubble_memwb=1, other bubbles 0; perf_flush_count unchanged.
REQ-023 Scenario: multiply accepted, resetn=0 at BUSY cycle 2 -> next cycle mdu_busy=0, all bubbles 1 during reset, perf counters 0.
REQ-024 Scenario: with PIPE_HAZARD_CTRL_PERF_EN, 10 imem_ready=0 cycles -> perf_stall_cycles=10; preload-equivalent wrap from 0xFFFFFFFF -> 0.
